// File: rtl/wallace_csa_multiplier_pkg.sv
// Shared definitions for the iterative carry-save multiplier front end.
// Holds the FSM state type, the fold rate and the default row width that
// the downstream carry-lookahead stage also uses.
package wallace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        HOLD
    } state_t;

    localparam int unsigned PP_PER_CYCLE  = 4;
    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned ITERS         = WIDTH_DEFAULT / PP_PER_CYCLE;
    localparam int unsigned ROW_WIDTH     = 2 * WIDTH_DEFAULT;

    // Number of COMPUTE cycles needed for an operand width.
    function automatic int unsigned iters_for(input int unsigned w);
        return w / PP_PER_CYCLE;
    endfunction

endpackage

// File: rtl/wallace_csa_multiplier_if.sv
// Operand/result handshake bundle for wallace_csa_multiplier.
//   in_valid/in_ready/a/b           : operand channel (master -> slave)
//   out_valid/out_ready/sum_row/carry_row : redundant result channel (slave -> master)
interface wallace_csa_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   sum_row;
    logic [2*WIDTH-1:0]   carry_row;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum_row, carry_row
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum_row, carry_row
    );
endinterface

// File: rtl/wallace_csa_multiplier_csa.sv
// csa_row: W-bit 3:2 compressor row.
//   x, y, z : input vectors
//   sum     : bitwise x^y^z
//   carry   : bitwise majority, shifted left by one; the bit leaving the row is dropped
module csa_row #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    logic [W-1:0] maj;

    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    assign carry = {maj[W-2:0], 1'b0};
endmodule

// File: rtl/wallace_csa_multiplier.sv
// wallace_csa_multiplier: iterative WIDTH x WIDTH unsigned multiplier front end.
// Folds four partial products per cycle into carry-save accumulators and
// presents the two redundant rows, whose modulo-2^(2*WIDTH) sum is a*b.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of wallace_csa_multiplier_if (operands in, rows out)
module wallace_csa_multiplier
    import wallace_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    wallace_csa_multiplier_if.slave       bus
);
    localparam int unsigned ROW    = 2 * WIDTH;
    localparam int unsigned NITERS = iters_for(WIDTH);
    localparam int unsigned KW     = (NITERS > 1) ? $clog2(NITERS) : 1;
    localparam int unsigned IDXW   = $clog2(WIDTH);

    state_t            state, state_nxt;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [ROW-1:0]    s_q, c_q;
    logic [ROW-1:0]    pp [PP_PER_CYCLE];
    logic [IDXW-1:0]   bit_idx;
    logic [ROW-1:0]    s1, c1, s2, c2, s3, c3, s_nxt, c_nxt;
    logic              accept, last;

    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == HOLD);
    assign bus.sum_row   = s_q;
    assign bus.carry_row = c_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (k == KW'(NITERS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = COMPUTE;
            COMPUTE: if (last) state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Partial products for bits 4k..4k+3 of the multiplier.
    always_comb begin
        bit_idx = '0;
        for (int unsigned j = 0; j < PP_PER_CYCLE; j++) begin
            bit_idx = IDXW'(PP_PER_CYCLE * 32'(k) + j);
            pp[j]   = b_q[bit_idx] ? (ROW'(a_q) << bit_idx) : '0;
        end
    end

    // 6 -> 4: {S, C, PP0} and {PP1, PP2, PP3}; 4 -> 3; 3 -> 2.
    csa_row #(.W(ROW)) u_l1a (.x(s_q), .y(c_q),   .z(pp[0]), .sum(s1),    .carry(c1));
    csa_row #(.W(ROW)) u_l1b (.x(pp[1]), .y(pp[2]), .z(pp[3]), .sum(s2),  .carry(c2));
    csa_row #(.W(ROW)) u_l2  (.x(s1),  .y(c1),    .z(s2),    .sum(s3),    .carry(c3));
    csa_row #(.W(ROW)) u_l3  (.x(s3),  .y(c3),    .z(c2),    .sum(s_nxt), .carry(c_nxt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            s_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                        s_q <= '0;
                        c_q <= '0;
                        k   <= '0;
                    end
                end
                COMPUTE: begin
                    s_q <= s_nxt;
                    c_q <= c_nxt;
                    k   <= last ? '0 : k + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/wallace_csa_multiplier.md
# wallace_csa_multiplier

Iterative 32x32 unsigned multiplier front end. It accumulates partial products in carry-save form and emits two redundant 64-bit rows, `sum_row` and `carry_row`, whose modulo-2^64 sum is the product. It sits directly upstream of the 64-bit carry-lookahead adder, which resolves the two rows into the final product. It folds four partial products per cycle through a 3:2-compressor tree and applies a valid/ready handshake on both sides.

## Interface
- `WIDTH`, default 32: operand width. Output rows are 2*WIDTH bits. WIDTH must be a multiple of 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. Synchronous and active-low, sampled on `clk`.
- `in_valid`  in  1  operands are valid.
- `in_ready`  out  1  block can accept operands. Equals (state==IDLE) && rst_n.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `out_valid`  out  1  rows are valid and held.
- `out_ready`  in  1  downstream (CLA stage) accepts the rows.
- `sum_row`  out  2*WIDTH  carry-save sum vector.
- `carry_row`  out  2*WIDTH  carry-save carry vector, already left-shifted.

## Operation
- States: IDLE, COMPUTE, HOLD.
- IDLE -> COMPUTE on `in_valid && in_ready`.
  - Capture `a` and `b`.
  - Clear the accumulators S and C to 0 and the iteration counter k to 0.
- Each COMPUTE cycle folds nibble k:
  - Form PP_j = b[4k+j] ? (a << (4k+j)) : 0, for j=0..3, zero-extended to 2*WIDTH.
  - Reduce the six operands {S, C, PP0..PP3} with 3:2 rows, 6 -> 4 -> 3 -> 2, into new S and C.
  - Each compressor produces sum = x^y^z and carry = maj(x,y,z) << 1, with bit 2*WIDTH dropped.
  - Then k++.
- COMPUTE -> HOLD after the last nibble, k = WIDTH/4 - 1. `out_valid` goes to 1.
- HOLD -> IDLE on `out_valid && out_ready`. `out_valid` goes to 0.
- Rows are held stable throughout HOLD.
- Invariant after iteration k: (S + C) mod 2^(2*WIDTH) == a * b[4k+3:0].
  - The final rows satisfy (sum_row + carry_row) mod 2^64 == a*b exactly.
- No early termination. Latency is fixed regardless of operand values.
- `in_valid` is ignored outside IDLE. Operands are not re-sampled during COMPUTE.
- Reset (`rst_n` low at any edge, including mid-COMPUTE or HOLD):
  - state=IDLE, k=0.
  - `sum_row`=0, `carry_row`=0, `out_valid`=0.
  - `in_ready`=0 while `rst_n` is low. The in-flight operation is discarded.
- `sum_row` and `carry_row` are the S/C registers themselves. They are valid only while `out_valid`=1.

## Timing
- Accept at edge T. Folds occur at edges T+1 .. T+8 for WIDTH=32.
- `out_valid` is high after edge T+8, i.e. 8 cycles after accept.
- Minimum spacing between accepts is 10 cycles:
  - 1 accept cycle,
  - 8 COMPUTE cycles,
  - at least 1 HOLD cycle when `out_ready`=1,
  - re-accept possible in the next IDLE cycle.
- No combinational path from `in_valid` or `out_ready` to any output. `in_ready` depends only on state and `rst_n`.
- The CSA tree is three compressor levels deep per cycle. No carry propagation occurs inside this block.

## Structure
- Package `wallace_pkg`:
  - the state enum `{IDLE, COMPUTE, HOLD}`,
  - localparam `PP_PER_CYCLE`=4,
  - `ITERS` = WIDTH/PP_PER_CYCLE,
  - row width 2*WIDTH, shared with the CLA stage.
- Sub-module `csa_row`: a parameterised-width 3:2 compressor row with outputs sum and shifted carry. It is instantiated four times for the 6 -> 2 reduction.
- Top level holds the FSM, counter, operand registers, partial-product generation and handshake.

## Test plan
- Max operands: a=0xFFFFFFFF, b=0xFFFFFFFF -> `out_valid` exactly 8 cycles after accept, and sum_row+carry_row mod 2^64 = 0xFFFFFFFE00000001.
- Zero multiplier: a=0x12345678, b=0 -> `sum_row`=0, `carry_row`=0, same 8-cycle latency.
- Single top bit: a=1, b=0x80000000 -> `sum_row`=0x0000000080000000, `carry_row`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD with `in_valid`=1 and new operands -> rows stable, `in_ready`=0, second operand set accepted only after the output handshake.
- Reset mid-operation: drop `rst_n` for 1 cycle at COMPUTE k=3 -> next cycle `out_valid`=0, rows=0, `in_ready`=1 after release, and a fresh a=3, b=5 yields a row sum of 15.
- Random: 1000 random a/b with random `out_ready` stalls -> every row pair sums mod 2^64 to a*b, and the CLA output matches.
